row_clear_shifter: RTL
======================

Name: row_clear_shifter

Overview:
- Consumer side of the full-row detection interface: accepts a "row N is complete" request plus the current 200-bit fallen-pieces board.
- Removes that row and shifts every row above it down by one, one row per clock.
- Returns the updated board with a one-cycle valid strobe and keeps a cleared-lines count for scoring.
- While working, `busy` is high; it drives the row scanner's `pause` so the scanner holds its row index until the shift completes.

Parameters:
- COLS, 10, cells per row.
- ROWS, 20, rows on the board; row 0 is the top row.
- ROW_W, 5, width of the row index.
- CNT_W, 16, width of `lines_cleared`.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear_req  in  1  request: row `clear_row` of `board_in` is complete.
- clear_row  in  ROW_W  index of the complete row.
- board_in  in  ROWS*COLS  current board; row r occupies bits [r*COLS +: COLS].
- busy  out  1  high while a clear is in progress; feed to the scanner's `pause`.
- board_out  out  ROWS*COLS  updated board after the last completed clear.
- board_valid  out  1  one-cycle strobe; `board_out` is new.
- lines_cleared  out  CNT_W  total rows cleared since reset, saturating.

Behaviour:
- Reset (`rst_n` low, async): state IDLE, internal pointer 0, working board 0, `board_out` 0, `board_valid` 0, `busy` 0, `lines_cleared` 0.
- Reset asserted mid-operation aborts the clear; no `board_valid` is produced and the count does not change.
- States: IDLE, SHIFT, DONE. `busy` = (state != IDLE), decoded from registered state.
- IDLE, accept edge E0:
  - If `clear_req`=1 and `clear_row` < ROWS: latch `board_in` into the working board, set ptr = `clear_row`, go to SHIFT.
  - If `clear_row` >= ROWS: ignore the request and stay IDLE.
  - If `clear_req`=0: no action.
- SHIFT, each edge:
  - If ptr > 0: working row[ptr] <= working row[ptr-1], ptr <= ptr-1.
  - If ptr == 0: working row 0 <= all zeros, `board_out` <= final working board, `lines_cleared` increments unless it is all ones, go to DONE.
- Timing for clear of row R:
  - Shifts occupy edges E1..E(R+1).
  - `board_valid` is high for exactly the cycle between E(R+1) and E(R+2).
  - DONE returns to IDLE at E(R+2); `busy` is high from E0 to E(R+2).
- Row-0 clear: a single SHIFT cycle; the result is the input with row 0 zeroed.
- Input handling during a clear:
  - `clear_req`, `clear_row` and `board_in` changes in SHIFT or DONE are ignored, not queued.
  - The working copy is isolated from `board_in`.
- The earliest next accept is the first IDLE cycle after DONE. The requester must re-test the same row, because the shifted-in row may itself be complete.
- `board_out` holds its value between completions.
- `lines_cleared` saturates at 2^CNT_W-1 and never wraps.
- Rows below R (indices > R) are never modified.

Optional Feature:
- Macro: ROW_CLEAR_FAST_EN.
- Defined:
  - The whole shift is done in one combinational step on the accept edge, and state goes straight to DONE.
  - For every R, `board_valid` is high in the cycle after E0 and `busy` falls at E1.
  - Counting, saturation and reset behaviour are unchanged.
- Undefined: one row per clock as specified above.

Test Plan:
- Reset, then `board_in` with row 19 all ones and row 18 = 10'b0000000011; `clear_req`=1, `clear_row`=19 -> `busy` high for 21 cycles; `board_valid` one cycle after the 20th shift edge; `board_out` row 19 = 10'b0000000011, row 0 = 0; `lines_cleared` = 1.
- `clear_row`=0, row 0 all ones, row 1 = 10'h155 -> one SHIFT cycle, `board_valid` 2 edges after accept; `board_out` row 0 = 0, row 1 = 10'h155 unchanged.
- During a clear of row 10, pulse `clear_req` with `clear_row`=5 and toggle `board_in` -> ignored; result matches the original request only; `lines_cleared` increments by 1.
- `clear_req`=1, `clear_row`=25 -> stays IDLE; `busy`, `board_valid` and `lines_cleared` unchanged.
- Assert `rst_n`=0 three cycles into a clear of row 12 -> all outputs 0 immediately (async); no `board_valid` after release.
- Preload the counter near saturation (CNT_W=2 build), perform 5 clears -> `lines_cleared` sticks at 3. Repeat with ROW_CLEAR_FAST_EN -> `board_valid` always 1 cycle after accept.

Source files
------------

// File: rtl/row_clear_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : row_clear_shifter
//  Description : Removes a completed row from the fallen-pieces board. Rows
//                above it move down one per clock. A scoring counter tracks
//                the cleared lines. Define ROW_CLEAR_FAST_EN to do the whole
//                shift in a single combinational step on the accept edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module row_clear_shifter #(
    parameter int COLS  = 10,
    parameter int ROWS  = 20,
    parameter int ROW_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_req,
    input  logic [ROW_W-1:0]     clear_row,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic                 busy,
    output logic [ROWS*COLS-1:0] board_out,
    output logic                 board_valid,
    output logic [CNT_W-1:0]     lines_cleared
);

    localparam int c_BITS = ROWS * COLS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    logic   w_accept;

    // An out-of-range row index is dropped rather than clamped.
    assign w_accept = clear_req && (int'(clear_row) < ROWS);
    assign busy     = (r_state != S_IDLE);

`ifdef ROW_CLEAR_FAST_EN
    logic [c_BITS-1:0] w_shifted;

    always_comb begin
        w_shifted = board_in;
        for (int r = 0; r < ROWS; r++) begin
            if (r == 0) begin
                w_shifted[0 +: COLS] = '0;
            end else if (r <= int'(clear_row)) begin
                w_shifted[r*COLS +: COLS] = board_in[(r-1)*COLS +: COLS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            board_out     <= '0;
            board_valid   <= 1'b0;
            lines_cleared <= '0;
        end else begin
            board_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        board_out   <= w_shifted;
                        board_valid <= 1'b1;
                        if (lines_cleared != '1) begin
                            lines_cleared <= lines_cleared + 1'b1;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    logic [c_BITS-1:0] r_work;
    logic [ROW_W-1:0]  r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_work        <= '0;
            r_ptr         <= '0;
            board_out     <= '0;
            board_valid   <= 1'b0;
            lines_cleared <= '0;
        end else begin
            board_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_work  <= board_in;
                        r_ptr   <= clear_row;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Walk upward from the cleared row, pulling each row down.
                    if (r_ptr != '0) begin
                        r_work[int'(r_ptr)*COLS +: COLS] <= r_work[(int'(r_ptr)-1)*COLS +: COLS];
                        r_ptr <= r_ptr - 1'b1;
                    end else begin
                        r_work[0 +: COLS] <= '0;
                        board_out         <= {r_work[c_BITS-1:COLS], {COLS{1'b0}}};
                        board_valid       <= 1'b1;
                        if (lines_cleared != '1) begin
                            lines_cleared <= lines_cleared + 1'b1;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule
`default_nettype wire
